// File: rtl/portb_int_ctrl.sv
// PORTB interrupt controller: pin synchronizer, RB0/INT edge detector and
// RB7:RB4 interrupt-on-change detector, with INTCON flag registers and a
// wake-from-SLEEP pulse.
//
// After reset, a priming window of SYNC_STAGES+1 cycles lets the synchronizer
// fill with real pin data. During that window the edge and change reference
// registers just follow pin_sync, so stale reset zeros can never look like an
// edge or a change once detection is enabled.
//
// SYNC_STAGES legal range is 2..4.

module portb_int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_sync,
  input  logic [7:0] tris,
  input  logic       intedg,
  input  logic       portb_rd,
  input  logic       portb_wr,
  input  logic       intf_wr_en,
  input  logic       intf_in,
  input  logic       rbif_wr_en,
  input  logic       rbif_in,
  output logic       intf,
  output logic       rbif,
  output logic       wake
);

  // Wide enough to hold the terminal count SYNC_STAGES.
  localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    StPrime,
    StRun
  } prime_state_e;

  // Synchronizer chain; stage 0 samples the raw pins.
  logic [7:0]      sync_q [SYNC_STAGES];

  // Priming state.
  prime_state_e    prime_state_q;
  logic [CntW-1:0] prime_cnt_q;
  logic            primed;

  // Edge / change reference registers.
  logic            prev0_q;
  logic [3:0]      ref_q;
  logic [3:0]      ref_d;

  // Detection.
  logic            int_evt;
  logic            rb_evt;
  logic [3:0]      mismatch;

  // Flags and wake.
  logic            intf_q;
  logic            intf_d;
  logic            rbif_q;
  logic            rbif_d;
  logic            wake_q;
  logic            wake_d;

  // TRISB bits 3:1 play no role in interrupt generation.
  logic            unused_tris;
  assign unused_tris = ^tris[3:1];

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------

  // Shift raw pin levels through the metastability chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign pin_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Priming FSM
  // ---------------------------------------------------------------------------

  // Count SYNC_STAGES+1 cycles after reset, then stay in StRun until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_state_q <= StPrime;
      prime_cnt_q   <= '0;
    end else begin
      unique case (prime_state_q)
        StPrime: begin
          if (prime_cnt_q == CntW'(SYNC_STAGES)) begin
            prime_state_q <= StRun;
          end else begin
            prime_cnt_q <= prime_cnt_q + CntW'(1);
          end
        end
        StRun: begin
          prime_state_q <= StRun;
        end
        default: begin
          prime_state_q <= StPrime;
        end
      endcase
    end
  end

  assign primed = (prime_state_q == StRun);

  // ---------------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------------

  // INT edge uses only the registered previous sample and the current level,
  // so toggling intedg alone can never fabricate an edge.
  always_comb begin
    int_evt = 1'b0;
    if (primed && tris[0]) begin
      if (intedg) begin
        int_evt = ~prev0_q & pin_sync[0];
      end else begin
        int_evt = prev0_q & ~pin_sync[0];
      end
    end
  end

  // Change detection against the last latched reference; output bits masked.
  always_comb begin
    mismatch = (pin_sync[7:4] ^ ref_q) & tris[7:4];
    rb_evt   = primed & (|mismatch);
  end

  // Reference follows pin_sync while priming and on any PORTB access.
  always_comb begin
    ref_d = ref_q;
    if (!primed || portb_rd || portb_wr) begin
      ref_d = pin_sync[7:4];
    end
  end

  // Previous RB0 sample and change reference registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev0_q <= 1'b0;
      ref_q   <= '0;
    end else begin
      prev0_q <= pin_sync[0];
      ref_q   <= ref_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Flags and wake
  // ---------------------------------------------------------------------------

  // Hardware set wins over a same-cycle software write. Wake only fires when
  // hardware is the cause of a 0->1 flag transition.
  always_comb begin
    intf_d = intf_q;
    if (int_evt) begin
      intf_d = 1'b1;
    end else if (intf_wr_en) begin
      intf_d = intf_in;
    end

    rbif_d = rbif_q;
    if (rb_evt) begin
      rbif_d = 1'b1;
    end else if (rbif_wr_en) begin
      rbif_d = rbif_in;
    end

    wake_d = (int_evt & ~intf_q) | (rb_evt & ~rbif_q);
  end

  // Flag and wake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      intf_q <= 1'b0;
      rbif_q <= 1'b0;
      wake_q <= 1'b0;
    end else begin
      intf_q <= intf_d;
      rbif_q <= rbif_d;
      wake_q <= wake_d;
    end
  end

  assign intf = intf_q;
  assign rbif = rbif_q;
  assign wake = wake_q;

endmodule

// File: tb/tb_portb_int_ctrl.sv
// Self-checking bench for portb_int_ctrl: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model
// built from a history of sampled pin values.

module tb_portb_int_ctrl;

  localparam int unsigned S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin_in;
  logic [7:0] pin_sync;
  logic [7:0] tris;
  logic       intedg;
  logic       portb_rd;
  logic       portb_wr;
  logic       intf_wr_en;
  logic       intf_in;
  logic       rbif_wr_en;
  logic       rbif_in;
  logic       intf;
  logic       rbif;
  logic       wake;

  always #5 clk = ~clk;

  portb_int_ctrl #(
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_in    (pin_in),
    .pin_sync  (pin_sync),
    .tris      (tris),
    .intedg    (intedg),
    .portb_rd  (portb_rd),
    .portb_wr  (portb_wr),
    .intf_wr_en(intf_wr_en),
    .intf_in   (intf_in),
    .rbif_wr_en(rbif_wr_en),
    .rbif_in   (rbif_in),
    .intf      (intf),
    .rbif      (rbif),
    .wake      (wake)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model: samp[k] is pin_in as captured k clock edges ago (zero after reset).
  logic [7:0]  samp [0:S+1];
  int unsigned n_edges;
  logic        m_intf;
  logic        m_rbif;
  logic        m_wake;
  logic [3:0]  m_ref;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_step();
    logic [7:0] ps;
    logic       p0;
    logic       is_primed;
    logic       int_ev;
    logic       rb_ev;
    logic       nx_intf;
    logic       nx_rbif;
    logic [3:0] mm;
    if (rst) begin
      for (int k = 0; k < S + 2; k++) samp[k] = '0;
      n_edges = 0;
      m_intf  = 1'b0;
      m_rbif  = 1'b0;
      m_wake  = 1'b0;
      m_ref   = '0;
    end else begin
      ps        = samp[S];
      p0        = samp[S+1][0];
      is_primed = (n_edges >= S + 1);
      int_ev    = is_primed && tris[0] &&
                  (intedg ? (!p0 && ps[0]) : (p0 && !ps[0]));
      mm        = (ps[7:4] ^ m_ref) & tris[7:4];
      rb_ev     = is_primed && (mm != 4'd0);
      nx_intf   = int_ev ? 1'b1 : (intf_wr_en ? intf_in : m_intf);
      nx_rbif   = rb_ev ? 1'b1 : (rbif_wr_en ? rbif_in : m_rbif);
      m_wake    = (int_ev && !m_intf) || (rb_ev && !m_rbif);
      m_intf    = nx_intf;
      m_rbif    = nx_rbif;
      if (!is_primed || portb_rd || portb_wr) m_ref = ps[7:4];
      for (int k = S + 1; k > 1; k--) samp[k] = samp[k-1];
      samp[1] = pin_in;
      if (n_edges < 1000) n_edges++;
    end
  endtask

  // One clock: update the model at the edge, compare just after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("pin_sync", pin_sync, samp[S]);
    check_eq("intf", intf, m_intf);
    check_eq("rbif", rbif, m_rbif);
    check_eq("wake", wake, m_wake);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic quiet();
    portb_rd   = 1'b0;
    portb_wr   = 1'b0;
    intf_wr_en = 1'b0;
    intf_in    = 1'b0;
    rbif_wr_en = 1'b0;
    rbif_in    = 1'b0;
  endtask

  initial begin
    int k;
    for (int j = 0; j < S + 2; j++) samp[j] = '0;
    n_edges = 0;
    m_intf  = 1'b0;
    m_rbif  = 1'b0;
    m_wake  = 1'b0;
    m_ref   = '0;
    quiet();
    rst    = 1'b1;
    pin_in = 8'hFF;
    tris   = 8'hFF;
    intedg = 1'b1;

    // Reset, then pins held high through priming: nothing may fire.
    run(2);
    check_eq("rst_intf", intf, 1'b0);
    check_eq("rst_rbif", rbif, 1'b0);
    check_eq("rst_pin_sync", pin_sync, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check_eq("prime_intf", intf, 1'b0);
      check_eq("prime_rbif", rbif, 1'b0);
      check_eq("prime_wake", wake, 1'b0);
    end

    // Rising RB0 edge: intf after S+1 cycles with a single wake pulse.
    tris   = 8'h01;
    pin_in = 8'h00;
    run(S + 3);
    pin_in = 8'h01;
    k = 0;
    do begin
      cycle();
      k++;
    end while (intf !== 1'b1 && k < 20);
    check_eq("int_latency", k, S + 1);
    check_eq("int_wake", wake, 1'b1);
    cycle();
    check_eq("int_wake_once", wake, 1'b0);
    pin_in = 8'h00;
    run(S + 3);
    check_eq("int_fall_ignored", intf, 1'b1);
    intf_wr_en = 1'b1;
    intf_in    = 1'b0;
    cycle();
    quiet();
    check_eq("intf_sw_clear", intf, 1'b0);

    // Change on RB5 with outputs masked off low nibble.
    tris = 8'hF0;
    run(S + 2);
    portb_rd = 1'b1;
    cycle();
    quiet();
    rbif_wr_en = 1'b1;
    cycle();
    quiet();
    cycle();
    check_eq("rb_idle", rbif, 1'b0);
    pin_in = 8'h20;
    k = 0;
    do begin
      cycle();
      k++;
    end while (rbif !== 1'b1 && k < 20);
    check_eq("rb_set", rbif, 1'b1);
    check_eq("rb_wake", wake, 1'b1);
    rbif_wr_en = 1'b1;
    cycle();
    quiet();
    cycle();
    check_eq("rb_persist", rbif, 1'b1);
    portb_rd = 1'b1;
    cycle();
    quiet();
    rbif_wr_en = 1'b1;
    cycle();
    quiet();
    run(3);
    check_eq("rb_cleared", rbif, 1'b0);

    // Upper nibble as outputs: toggling there never sets rbif.
    tris = 8'h0F;
    for (int i = 0; i < 6; i++) begin
      pin_in = (i % 2 == 0) ? 8'hD0 : 8'h20;
      run(2);
      check_eq("rb_masked", rbif, 1'b0);
    end

    // INT event coincident with a software write of 0: hardware wins.
    tris   = 8'h01;
    pin_in = 8'h00;
    run(S + 3);
    pin_in = 8'h01;
    run(S);
    intf_wr_en = 1'b1;
    intf_in    = 1'b0;
    cycle();
    quiet();
    check_eq("hw_prio_intf", intf, 1'b1);
    check_eq("hw_prio_wake", wake, 1'b1);
    intf_wr_en = 1'b1;
    cycle();
    quiet();
    check_eq("intf_clr2", intf, 1'b0);
    intf_wr_en = 1'b1;
    intf_in    = 1'b1;
    cycle();
    quiet();
    check_eq("sw_set_intf", intf, 1'b1);
    check_eq("sw_set_nowake", wake, 1'b0);
    intf_wr_en = 1'b1;
    cycle();
    quiet();

    // Reset lands between the synchronized edge and the flag set.
    pin_in = 8'h00;
    run(S + 3);
    pin_in = 8'h01;
    run(S);
    rst = 1'b1;
    cycle();
    check_eq("rst_mid_intf", intf, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < S + 4; i++) begin
      cycle();
      check_eq("reprime_intf", intf, 1'b0);
      check_eq("reprime_rbif", rbif, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
      if ($urandom_range(0, 31) == 0) tris = 8'($urandom);
      if ($urandom_range(0, 31) == 0) intedg = 1'($urandom);
      portb_rd   = ($urandom_range(0, 7) == 0);
      portb_wr   = ($urandom_range(0, 15) == 0);
      intf_wr_en = ($urandom_range(0, 7) == 0);
      intf_in    = 1'($urandom);
      rbif_wr_en = ($urandom_range(0, 7) == 0);
      rbif_in    = 1'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
